// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, stall/flush handling
// and EX/MEM + MEM/WB operand forwarding for the 5-stage RISC-V core.

// One forwarding mux per source operand; EX/MEM is younger so it wins.
module id_ex_fwd (
    input  logic [4:0]  idx,
    input  logic [31:0] reg_data,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic [31:0] data
);
    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_reg_write & (exm_rd != 5'd0) & (exm_rd == idx);
    assign mwb_hit = mwb_reg_write & (mwb_rd != 5'd0) & (mwb_rd == idx);

    always_comb begin
        data = reg_data;
        if (exm_hit)
            data = exm_result;
        else if (mwb_hit)
            data = mwb_result;
    end
endmodule

module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_use_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_is_branch,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_alu_ctrl,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic        load_use_stall,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_is_branch,
    output logic [4:0]  ex_rd
);
    localparam int NUM_SRC = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_ctrl;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    id_ex_t id_in;

    logic [NUM_SRC-1:0][4:0]  src_idx;
    logic [NUM_SRC-1:0][31:0] src_reg;
    logic [NUM_SRC-1:0][31:0] src_fwd;

    always_comb begin
        id_in           = '0;
        id_in.valid     = id_valid;
        id_in.pc        = id_pc;
        id_in.rs1_data  = id_rs1_data;
        id_in.rs2_data  = id_rs2_data;
        id_in.imm       = id_imm;
        id_in.rs1       = id_rs1;
        id_in.rs2       = id_rs2;
        id_in.rd        = id_rd;
        id_in.alu_ctrl  = id_alu_ctrl;
        id_in.use_imm   = id_use_imm;
        id_in.reg_write = id_reg_write;
        id_in.mem_read  = id_mem_read;
        id_in.mem_write = id_mem_write;
        id_in.is_branch = id_is_branch;
    end

    // A load in EX whose destination is read by the ID instruction must bubble.
    assign load_use_stall = id_valid & q.valid & q.mem_read & (q.rd != 5'd0)
                          & ((q.rd == id_rs1) | (q.rd == id_rs2));

    assign src_idx[0] = q.rs1;
    assign src_idx[1] = q.rs2;
    assign src_reg[0] = q.rs1_data;
    assign src_reg[1] = q.rs2_data;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        id_ex_fwd u_fwd (
            .idx           (src_idx[g]),
            .reg_data      (src_reg[g]),
            .exm_reg_write (exm_reg_write),
            .exm_rd        (exm_rd),
            .exm_result    (exm_result),
            .mwb_reg_write (mwb_reg_write),
            .mwb_rd        (mwb_rd),
            .mwb_result    (mwb_result),
            .data          (src_fwd[g])
        );
    end

    // While stalled, operand data tracks the forwarded value so a MEM/WB
    // result retiring during the hold is not lost once it leaves the pipe.
    always_comb begin
        d = q;
        if (flush) begin
            d = '0;
        end else if (stall) begin
            d.rs1_data = src_fwd[0];
            d.rs2_data = src_fwd[1];
        end else if (load_use_stall) begin
            d = '0;
        end else begin
            d = id_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= d;
    end

    assign alu_in1       = src_fwd[0];
    assign alu_in2       = q.use_imm ? q.imm : src_fwd[1];
    assign ex_store_data = src_fwd[1];
    assign alu_ctrl      = q.alu_ctrl;
    assign ex_pc         = q.pc;
    assign ex_valid      = q.valid;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_is_branch  = q.is_branch;
    assign ex_rd         = q.rd;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-select stage between instruction decode and the ALU in the 5-stage RISC-V core. It latches decoded fields once per cycle, detects load-use hazards, applies stall/flush, and forwards EX/MEM and MEM/WB results. It drives the ALU operand, control and PC inputs plus the control bits carried to the memory stage.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  global hold from memory/fetch; freezes this register
- flush  in  1  branch redirect; next state is a bubble
- id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write, id_is_branch  in  1 each  decoded control bits
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  decoded data; register file reads are write-first
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_alu_ctrl  in  4  ALU op code (0 ADD … A AUIPC)
- exm_reg_write  in  1; exm_rd  in  5; exm_result  in  32  EX/MEM forwarding source
- mwb_reg_write  in  1; mwb_rd  in  5; mwb_result  in  32  MEM/WB forwarding source
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID when high
- alu_in1, alu_in2  out  32  ALU operands
- alu_ctrl  out  4; ex_pc  out  32  ALU control and PC
- ex_store_data  out  32  forwarded rs2 for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch  out  1 each
- ex_rd  out  5

## Operation
- Registered state: valid, pc, rs1/rs2 data, imm, rs1/rs2/rd indices, alu_ctrl, use_imm, reg_write, mem_read, mem_write, is_branch.
- load_use_stall = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Per-cycle update, priority order:
  1. flush: load bubble (all state zero).
  2. stall: hold all state, except rs1/rs2 data fields capture their forwarded values (prevents losing a MEM/WB result that retires during the stall).
  3. load_use_stall: load bubble.
  4. otherwise load all id_* fields.
- Forwarding, per source operand (rs1, rs2), combinational from registered state:
  - If exm_reg_write & exm_rd≠0 & exm_rd==index, select exm_result.
  - Else if mwb_reg_write & mwb_rd≠0 & mwb_rd==index, select mwb_result.
  - Else select the registered data.
- alu_in1 = fwd_rs1.
- alu_in2 = use_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2.
- alu_ctrl, ex_pc, ex_rd and the control outputs come straight from registered state.
- A bubble presents alu_ctrl=0 and zero operands unless forwarding hits x-indices 0. It cannot hit, because index 0 is never forwarded, so operands are 0.

## Timing
- Latency: id_* sampled at edge N, visible on ex_* and alu_* after edge N.
- Reset (rst_n low, asynchronous): every registered field is 0. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_rd, alu_ctrl, ex_pc, alu_in1, alu_in2 and ex_store_data all read 0. load_use_stall reads 0 because ex_valid=0.
- Reset deassertion mid-stream: first edge after release behaves per the priority list; no special state.
- flush and stall together: flush wins; bubble is loaded.
- load_use_stall never asserts two consecutive cycles for one instruction: the bubble clears ex_mem_read.
- id_valid=0 with no flush/stall: state loads as given, i.e. a bubble.
- Both forwarding sources match: EX/MEM wins (younger).
- rd=0 never forwards; x0 writes are ignored.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release, load ADD pc=0x100, rs1_data=5, rs2_data=7 -> next cycle alu_in1=5, alu_in2=7, alu_ctrl=0, ex_pc=0x100, ex_valid=1.
- Forwarding priority: registered rs1=3, exm_rd=3/exm_result=0xAA, mwb_rd=3/mwb_result=0xBB, both write enables high -> alu_in1=0xAA; drop exm_reg_write -> 0xBB; set both rd=0 -> registered data.
- Load-use: EX holds LW rd=4 (ex_mem_read=1), ID has rs2=4 -> load_use_stall=1. Next cycle: ex_valid=0, ex_reg_write=0, load_use_stall=0. Following cycle the ID instruction loads.
- Flush: assert flush with a valid SUB at ID and stall=1 -> next cycle ex_valid=0, all control outputs 0, alu_ctrl=0.
- Stall capture: hold stall 2 cycles with registered rs1=9. mwb_rd=9/mwb_result=0x1234 on the first stall cycle only -> after release, alu_in1=0x1234 with no forwarding source active.
- Immediate select: use_imm=1, imm=0xFFFFFFFC, rs2 forwarded to 0x55 -> alu_in2=0xFFFFFFFC, ex_store_data=0x55.
